// File: rtl/stereo_sample_mixer_pkg.sv
// stereo_sample_mixer_pkg
//   Shared types and helpers for the stereo sample mixer.
//   - mixer_state_t      : frame-sequencer states
//   - MIXER_NUM_CHANNELS : default channel count per frame
//   - saturate()         : clamps a wide signed value to a signed field width
package stereo_sample_mixer_pkg;

   localparam int MIXER_NUM_CHANNELS = 9;

   // Working width for saturation arithmetic; every intermediate sum in the
   // mixer and DC blocker is sign-extended to this before clamping.
   localparam int SAT_WIDTH = 64;

   typedef enum logic {
      MIX_ACCUM  = 1'b0,
      MIX_RESYNC = 1'b1
   } mixer_state_t;

   function automatic logic signed [SAT_WIDTH-1:0] saturate(
      input logic signed [SAT_WIDTH-1:0] value,
      input int                          width
   );
      logic signed [SAT_WIDTH-1:0] max_v;
      logic signed [SAT_WIDTH-1:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v) begin
         return max_v;
      end
      if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage

// File: rtl/stereo_sample_mixer_dc_blocker.sv
// stereo_sample_mixer_dc_blocker
//   One-side DC-blocking high-pass: y = x - x_prev + y_prev - (y_prev >>> DC_SHIFT),
//   computed in OUT_WIDTH+2 bits and re-saturated to OUT_WIDTH. State advances
//   only when in_valid is high. Used by the mixer when OPL2_MIXER_DC_BLOCK_EN
//   is defined.
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   in_valid in   new saturated sample on x_in
//   x_in     in   signed input sample (OUT_WIDTH)
//   y_out    out  filtered, re-saturated sample (registered)
//   y_clip   out  the last filtered sample needed re-saturation
module stereo_sample_mixer_dc_blocker
   import stereo_sample_mixer_pkg::*;
#(
   parameter int OUT_WIDTH = 24,
   parameter int DC_SHIFT  = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [OUT_WIDTH-1:0] x_in,
   output logic [OUT_WIDTH-1:0] y_out,
   output logic                 y_clip
);

   localparam int FW = OUT_WIDTH + 2;

   logic [OUT_WIDTH-1:0] x_prev_q, x_prev_d;
   logic [OUT_WIDTH-1:0] y_prev_q, y_prev_d;
   logic                 clip_q, clip_d;

   logic signed [FW-1:0]        x_w, xp_w, yp_w, y_w;
   logic signed [SAT_WIDTH-1:0] y_wide, y_sat;

   always_comb begin
      x_w    = {{2{x_in[OUT_WIDTH-1]}}, x_in};
      xp_w   = {{2{x_prev_q[OUT_WIDTH-1]}}, x_prev_q};
      yp_w   = {{2{y_prev_q[OUT_WIDTH-1]}}, y_prev_q};
      // Two guard bits are enough: |x - x_prev| < 2^OUT_WIDTH and the leak
      // term never pushes y_prev past its own magnitude.
      y_w    = x_w - xp_w + yp_w - (yp_w >>> DC_SHIFT);
      y_wide = {{(SAT_WIDTH-FW){y_w[FW-1]}}, y_w};
      y_sat  = saturate(y_wide, OUT_WIDTH);

      x_prev_d = x_prev_q;
      y_prev_d = y_prev_q;
      clip_d   = clip_q;
      if (in_valid) begin
         x_prev_d = x_in;
         y_prev_d = y_sat[OUT_WIDTH-1:0];
         clip_d   = (y_sat != y_wide);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_prev_q <= '0;
         y_prev_q <= '0;
         clip_q   <= 1'b0;
      end else begin
         x_prev_q <= x_prev_d;
         y_prev_q <= y_prev_d;
         clip_q   <= clip_d;
      end
   end

   assign y_out  = y_prev_q;
   assign y_clip = clip_q;

endmodule

// File: rtl/stereo_sample_mixer.sv
// stereo_sample_mixer
//   Sums a time-multiplexed frame of per-channel samples (indices 0..N-1 in
//   order) into left/right buses under pan masks, applies gain and saturation,
//   and presents one stereo sample per frame on a valid/ready output register.
//   Optional DC-blocking high-pass per side when OPL2_MIXER_DC_BLOCK_EN is
//   defined (adds one pipeline stage).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   channel_valid/index/channel  incoming tagged channel sample
//   pan_left, pan_right          bit i routes channel i to that side
//   sample_ready                 downstream accepts the held sample
//   sample_valid                 stereo sample held in output register
//   sample_left, sample_right    signed stereo output
//   clip                         pulse: loaded frame was saturated
//   frame_error                  pulse: out-of-sequence index, frame discarded
//   overrun                      pulse: completed frame dropped, output held
//
// state      | meaning
// -----------+------------------------------------------------------------
// MIX_ACCUM  | accumulating a frame; exp_q is the next index expected
// MIX_RESYNC | after a sequence error; ignoring samples until index 0
module stereo_sample_mixer
   import stereo_sample_mixer_pkg::*;
#(
   parameter  int NUM_CHANNELS = MIXER_NUM_CHANNELS,
   parameter  int IN_WIDTH     = 16,
   parameter  int OUT_WIDTH    = 24,
   parameter  int GAIN_SHIFT   = 2,
   parameter  int DC_SHIFT     = 10,
   localparam int IDX_WIDTH    = $clog2(NUM_CHANNELS)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    channel_valid,
   input  logic [IDX_WIDTH-1:0]    channel_index,
   input  logic [IN_WIDTH-1:0]     channel,
   input  logic [NUM_CHANNELS-1:0] pan_left,
   input  logic [NUM_CHANNELS-1:0] pan_right,
   input  logic                    sample_ready,
   output logic                    sample_valid,
   output logic [OUT_WIDTH-1:0]    sample_left,
   output logic [OUT_WIDTH-1:0]    sample_right,
   output logic                    clip,
   output logic                    frame_error,
   output logic                    overrun
);

   localparam int ACC_WIDTH = IN_WIDTH + $clog2(NUM_CHANNELS);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CHANNELS - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);

   if (NUM_CHANNELS < 2 || DC_SHIFT < 1 || ACC_WIDTH + GAIN_SHIFT >= SAT_WIDTH ||
       OUT_WIDTH + 2 >= SAT_WIDTH) begin : g_bad_cfg
      $error("stereo_sample_mixer: unsupported parameter combination");
   end

   // ---------------------------------------------------------------- accumulate
   mixer_state_t             state_q, state_d;
   logic [IDX_WIDTH-1:0]     exp_q, exp_d;
   logic signed [ACC_WIDTH-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
   logic                     frame_done_q, frame_done_d;
   logic                     frame_error_q, frame_error_d;

   logic                        pan_l_sel, pan_r_sel;
   logic signed [ACC_WIDTH-1:0] samp_ext, term_l, term_r;

   // Pan bit looked up by compare so an out-of-range index never selects past
   // the mask; such indices are always sequence errors anyway.
   always_comb begin
      pan_l_sel = 1'b0;
      pan_r_sel = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (channel_index == IDX_WIDTH'(i)) begin
            pan_l_sel = pan_left[i];
            pan_r_sel = pan_right[i];
         end
      end
   end

   assign samp_ext = {{(ACC_WIDTH-IN_WIDTH){channel[IN_WIDTH-1]}}, channel};
   assign term_l   = pan_l_sel ? samp_ext : '0;
   assign term_r   = pan_r_sel ? samp_ext : '0;

   always_comb begin
      state_d       = state_q;
      exp_d         = exp_q;
      acc_l_d       = acc_l_q;
      acc_r_d       = acc_r_q;
      frame_done_d  = 1'b0;
      frame_error_d = 1'b0;
      if (channel_valid) begin
         case (state_q)
            MIX_ACCUM: begin
               if (channel_index == exp_q) begin
                  if (exp_q == '0) begin
                     acc_l_d = term_l;
                     acc_r_d = term_r;
                  end else begin
                     acc_l_d = acc_l_q + term_l;
                     acc_r_d = acc_r_q + term_r;
                  end
                  if (exp_q == LAST_IDX) begin
                     exp_d        = '0;
                     frame_done_d = 1'b1;
                  end else begin
                     exp_d = exp_q + IDX_ONE;
                  end
               end else begin
                  frame_error_d = 1'b1;
                  if (channel_index == '0) begin
                     // A stray index 0 restarts the frame with this sample.
                     acc_l_d = term_l;
                     acc_r_d = term_r;
                     exp_d   = IDX_ONE;
                  end else begin
                     state_d = MIX_RESYNC;
                     exp_d   = '0;
                  end
               end
            end
            MIX_RESYNC: begin
               if (channel_index == '0) begin
                  acc_l_d = term_l;
                  acc_r_d = term_r;
                  exp_d   = IDX_ONE;
                  state_d = MIX_ACCUM;
               end
            end
            default: begin
               state_d = MIX_ACCUM;
               exp_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= MIX_ACCUM;
         exp_q         <= '0;
         acc_l_q       <= '0;
         acc_r_q       <= '0;
         frame_done_q  <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         exp_q         <= exp_d;
         acc_l_q       <= acc_l_d;
         acc_r_q       <= acc_r_d;
         frame_done_q  <= frame_done_d;
         frame_error_q <= frame_error_d;
      end
   end

   // ---------------------------------------------------------------- scale
   // Reads the accumulators on the edge after the last channel, the same edge
   // the next frame's index 0 overwrites them, so back-to-back frames need no
   // bubble.
   logic signed [SAT_WIDTH-1:0] ext_l, ext_r, wide_l, wide_r, sat_l, sat_r;
   logic                        scale_valid_q, scale_valid_d;
   logic [OUT_WIDTH-1:0]        scale_l_q, scale_l_d, scale_r_q, scale_r_d;
   logic                        scale_clip_q, scale_clip_d;

   always_comb begin
      ext_l  = {{(SAT_WIDTH-ACC_WIDTH){acc_l_q[ACC_WIDTH-1]}}, acc_l_q};
      ext_r  = {{(SAT_WIDTH-ACC_WIDTH){acc_r_q[ACC_WIDTH-1]}}, acc_r_q};
      wide_l = ext_l <<< GAIN_SHIFT;
      wide_r = ext_r <<< GAIN_SHIFT;
      sat_l  = saturate(wide_l, OUT_WIDTH);
      sat_r  = saturate(wide_r, OUT_WIDTH);

      scale_valid_d = frame_done_q;
      scale_l_d     = scale_l_q;
      scale_r_d     = scale_r_q;
      scale_clip_d  = scale_clip_q;
      if (frame_done_q) begin
         scale_l_d    = sat_l[OUT_WIDTH-1:0];
         scale_r_d    = sat_r[OUT_WIDTH-1:0];
         scale_clip_d = (sat_l != wide_l) || (sat_r != wide_r);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scale_valid_q <= 1'b0;
         scale_l_q     <= '0;
         scale_r_q     <= '0;
         scale_clip_q  <= 1'b0;
      end else begin
         scale_valid_q <= scale_valid_d;
         scale_l_q     <= scale_l_d;
         scale_r_q     <= scale_r_d;
         scale_clip_q  <= scale_clip_d;
      end
   end

   // ---------------------------------------------------------------- optional DC block
   logic                 pre_valid;
   logic [OUT_WIDTH-1:0] pre_left, pre_right;
   logic                 pre_clip;

`ifdef OPL2_MIXER_DC_BLOCK_EN
   logic dc_valid_q, dc_valid_d;
   logic dc_scale_clip_q, dc_scale_clip_d;
   logic dc_clip_l, dc_clip_r;

   // Filters run on every completed frame, independent of whether the output
   // register later accepts it.
   stereo_sample_mixer_dc_blocker #(
      .OUT_WIDTH (OUT_WIDTH),
      .DC_SHIFT  (DC_SHIFT)
   ) u_dc_left (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (scale_valid_q),
      .x_in     (scale_l_q),
      .y_out    (pre_left),
      .y_clip   (dc_clip_l)
   );

   stereo_sample_mixer_dc_blocker #(
      .OUT_WIDTH (OUT_WIDTH),
      .DC_SHIFT  (DC_SHIFT)
   ) u_dc_right (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (scale_valid_q),
      .x_in     (scale_r_q),
      .y_out    (pre_right),
      .y_clip   (dc_clip_r)
   );

   always_comb begin
      dc_valid_d      = scale_valid_q;
      dc_scale_clip_d = scale_valid_q ? scale_clip_q : dc_scale_clip_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dc_valid_q      <= 1'b0;
         dc_scale_clip_q <= 1'b0;
      end else begin
         dc_valid_q      <= dc_valid_d;
         dc_scale_clip_q <= dc_scale_clip_d;
      end
   end

   assign pre_valid = dc_valid_q;
   assign pre_clip  = dc_scale_clip_q | dc_clip_l | dc_clip_r;
`else
   assign pre_valid = scale_valid_q;
   assign pre_left  = scale_l_q;
   assign pre_right = scale_r_q;
   assign pre_clip  = scale_clip_q;
`endif

   // ---------------------------------------------------------------- output register
   logic                 load_en;
   logic                 sample_valid_q, sample_valid_d;
   logic [OUT_WIDTH-1:0] left_q, left_d, right_q, right_d;
   logic                 clip_q, clip_d;
   logic                 overrun_q, overrun_d;

   always_comb begin
      load_en        = pre_valid && (!sample_valid_q || sample_ready);
      sample_valid_d = sample_valid_q;
      left_d         = left_q;
      right_d        = right_q;
      if (load_en) begin
         sample_valid_d = 1'b1;
         left_d         = pre_left;
         right_d        = pre_right;
      end else if (sample_ready) begin
         sample_valid_d = 1'b0;
      end
      clip_d    = load_en && pre_clip;
      overrun_d = pre_valid && !load_en;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_valid_q <= 1'b0;
         left_q         <= '0;
         right_q        <= '0;
         clip_q         <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         sample_valid_q <= sample_valid_d;
         left_q         <= left_d;
         right_q        <= right_d;
         clip_q         <= clip_d;
         overrun_q      <= overrun_d;
      end
   end

   assign sample_valid = sample_valid_q;
   assign sample_left  = left_q;
   assign sample_right = right_q;
   assign clip         = clip_q;
   assign frame_error  = frame_error_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_stereo_sample_mixer.sv
// tb_stereo_sample_mixer
//   Randomized and directed stimulus against a frame-level arithmetic model.
//   Two instances share the input stream: default gain, and GAIN_SHIFT=8 with
//   sample_ready tied high for the saturation cases.
module tb_stereo_sample_mixer;

   localparam int NCH      = 9;
   localparam int IW       = 4;
   localparam int OW       = 24;
   localparam int DC_SHIFT = 10;
`ifdef OPL2_MIXER_DC_BLOCK_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic           clk = 1'b0;
   logic           reset_n;
   logic           channel_valid;
   logic [IW-1:0]  channel_index;
   logic [15:0]    channel;
   logic [NCH-1:0] pan_left, pan_right;
   logic           sample_ready;
   logic           sample_valid, clip, frame_error, overrun;
   logic [OW-1:0]  sample_left, sample_right;
   logic           g8_valid, g8_clip, g8_frame_error, g8_overrun;
   logic [OW-1:0]  g8_left, g8_right;
   logic           one = 1'b1;

   stereo_sample_mixer #(.NUM_CHANNELS(NCH), .IN_WIDTH(16), .OUT_WIDTH(OW),
                         .GAIN_SHIFT(2), .DC_SHIFT(DC_SHIFT)) u_dut (
      .clk(clk), .reset_n(reset_n), .channel_valid(channel_valid),
      .channel_index(channel_index), .channel(channel), .pan_left(pan_left),
      .pan_right(pan_right), .sample_ready(sample_ready), .sample_valid(sample_valid),
      .sample_left(sample_left), .sample_right(sample_right), .clip(clip),
      .frame_error(frame_error), .overrun(overrun));

   stereo_sample_mixer #(.NUM_CHANNELS(NCH), .IN_WIDTH(16), .OUT_WIDTH(OW),
                         .GAIN_SHIFT(8), .DC_SHIFT(DC_SHIFT)) u_dut_g8 (
      .clk(clk), .reset_n(reset_n), .channel_valid(channel_valid),
      .channel_index(channel_index), .channel(channel), .pan_left(pan_left),
      .pan_right(pan_right), .sample_ready(one), .sample_valid(g8_valid),
      .sample_left(g8_left), .sample_right(g8_right), .clip(g8_clip),
      .frame_error(g8_frame_error), .overrun(g8_overrun));

   always #5 clk = ~clk;

   typedef struct {longint l; longint r;} out_t;

   out_t   act_q [2][$];
   out_t   exp_q [2][$];
   int     clip_cnt [2];
   int     exp_clip [2];
   int     fe_cnt, fe8_cnt, ovr_cnt, ovr8_cnt;
   int     exp_fe, exp_ovr;
   int     vectors, miscompares;
   int     fr [NCH];
`ifdef OPL2_MIXER_DC_BLOCK_EN
   longint dc_x [2][2];
   longint dc_y [2][2];
`endif

   task automatic check_val(input string tag, input longint got, input longint want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   function automatic longint sat_out(input longint v);
      if (v > 64'sd8388607)  return 64'sd8388607;
      if (v < -64'sd8388608) return -64'sd8388608;
      return v;
   endfunction

   task automatic model_reset();
`ifdef OPL2_MIXER_DC_BLOCK_EN
      for (int k = 0; k < 2; k++) begin
         for (int s = 0; s < 2; s++) begin
            dc_x[k][s] = 0;
            dc_y[k][s] = 0;
         end
      end
`endif
   endtask

   // Expected stereo result of the frame in fr[] under the current pans.
   task automatic model_frame(input bit load_main);
      for (int k = 0; k < 2; k++) begin
         longint sum_l, sum_r, wl, wr, yl, yr;
         bit     c;
         sum_l = 0;
         sum_r = 0;
         for (int i = 0; i < NCH; i++) begin
            if (pan_left[i])  sum_l += fr[i];
            if (pan_right[i]) sum_r += fr[i];
         end
         wl = sum_l * ((k == 0) ? 4 : 256);
         wr = sum_r * ((k == 0) ? 4 : 256);
         yl = sat_out(wl);
         yr = sat_out(wr);
         c  = (yl != wl) || (yr != wr);
`ifdef OPL2_MIXER_DC_BLOCK_EN
         begin
            longint ul, ur, fl, fr2;
            ul  = yl - dc_x[k][0] + dc_y[k][0] - (dc_y[k][0] >>> DC_SHIFT);
            ur  = yr - dc_x[k][1] + dc_y[k][1] - (dc_y[k][1] >>> DC_SHIFT);
            fl  = sat_out(ul);
            fr2 = sat_out(ur);
            c   = c || (fl != ul) || (fr2 != ur);
            dc_x[k][0] = yl;
            dc_x[k][1] = yr;
            dc_y[k][0] = fl;
            dc_y[k][1] = fr2;
            yl = fl;
            yr = fr2;
         end
`endif
         if (k == 1 || load_main) begin
            exp_q[k].push_back('{yl, yr});
            if (c) exp_clip[k]++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive_sample(input int idx, input int val);
      channel_valid = 1'b1;
      channel_index = IW'(idx);
      channel       = 16'(val);
      @(posedge clk);
      #1;
      channel_valid = 1'b0;
   endtask

   task automatic send_frame(input int max_gap, input bit load_main);
      for (int i = 0; i < NCH; i++) begin
         drive_sample(i, fr[i]);
         if (i != NCH - 1 && max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      end
      model_frame(load_main);
   endtask

   task automatic fill(input int v);
      for (int i = 0; i < NCH; i++) fr[i] = v;
   endtask

   task automatic checkpoint(input string tag);
      idle(LAT + 3);
      for (int k = 0; k < 2; k++) begin
         check_val($sformatf("%s_count%0d", tag, k), act_q[k].size(), exp_q[k].size());
         while (act_q[k].size() > 0 && exp_q[k].size() > 0) begin
            out_t a, e;
            a = act_q[k].pop_front();
            e = exp_q[k].pop_front();
            check_val($sformatf("%s_left%0d", tag, k), a.l, e.l);
            check_val($sformatf("%s_right%0d", tag, k), a.r, e.r);
         end
         act_q[k].delete();
         exp_q[k].delete();
         check_val($sformatf("%s_clip%0d", tag, k), clip_cnt[k], exp_clip[k]);
      end
      check_val({tag, "_ferr"}, fe_cnt, exp_fe);
      check_val({tag, "_ferr8"}, fe8_cnt, exp_fe);
      check_val({tag, "_ovr"}, ovr_cnt, exp_ovr);
      check_val({tag, "_ovr8"}, ovr8_cnt, 0);
   endtask

   always @(negedge clk) begin
      if (sample_valid && sample_ready)
         act_q[0].push_back('{longint'($signed(sample_left)), longint'($signed(sample_right))});
      if (g8_valid)
         act_q[1].push_back('{longint'($signed(g8_left)), longint'($signed(g8_right))});
      if (clip)           clip_cnt[0] <= clip_cnt[0] + 1;
      if (g8_clip)        clip_cnt[1] <= clip_cnt[1] + 1;
      if (frame_error)    fe_cnt      <= fe_cnt + 1;
      if (g8_frame_error) fe8_cnt     <= fe8_cnt + 1;
      if (overrun)        ovr_cnt     <= ovr_cnt + 1;
      if (g8_overrun)     ovr8_cnt    <= ovr8_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached before the bench finished");
      $fatal(1);
   end

   initial begin
      vectors = 0; miscompares = 0;
      fe_cnt = 0; fe8_cnt = 0; ovr_cnt = 0; ovr8_cnt = 0;
      exp_fe = 0; exp_ovr = 0;
      clip_cnt[0] = 0; clip_cnt[1] = 0; exp_clip[0] = 0; exp_clip[1] = 0;
      model_reset();
      reset_n = 1'b0; channel_valid = 1'b0; channel_index = '0; channel = '0;
      pan_left = '1; pan_right = '0; sample_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_valid", sample_valid, 0);
      check_val("rst_left", sample_left, 0);
      check_val("rst_right", sample_right, 0);
      check_val("rst_clip", clip, 0);
      check_val("rst_ferr", frame_error, 0);
      check_val("rst_ovr", overrun, 0);
      reset_n = 1'b1;
      idle(2);

      // Held sample and a partial frame both discarded by reset.
      sample_ready = 1'b0;
      fill(1000);
      send_frame(0, 1'b0);
      idle(LAT + 1);
      check_val("held_valid", sample_valid, 1);
      for (int i = 0; i < 5; i++) drive_sample(i, 1000);
      reset_n = 1'b0;
      #1;
      check_val("midrst_valid", sample_valid, 0);
      check_val("midrst_left", sample_left, 0);
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      sample_ready = 1'b1;
      idle(1);

      // Clean frame of 1000s: left 36000, valid exactly LAT edges after capture.
      fill(1000);
      send_frame(0, 1'b1);
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         check_val("lat_low", sample_valid, 0);
      end
      @(negedge clk);
      check_val("lat_high", sample_valid, 1);
      check_val("first_left", longint'($signed(sample_left)), 36000);
      check_val("first_right", longint'($signed(sample_right)), 0);
      checkpoint("reset");

      // Saturation on the high-gain instance.
      pan_left = '1; pan_right = '1;
      fill(32767);
      send_frame(1, 1'b1);
      fill(-32768);
      send_frame(1, 1'b1);
      checkpoint("clip");

      // Sequence errors.
      pan_left = '1; pan_right = '0;
      drive_sample(0, 1000); drive_sample(1, 1000); drive_sample(2, 1000);
      drive_sample(5, 1000);
      exp_fe++;
      drive_sample(7, 1000); drive_sample(8, 1000);
      fill(500);
      send_frame(0, 1'b1);
      drive_sample(0, 111); drive_sample(1, 222);
      exp_fe++;
      fill(700);
      send_frame(0, 1'b1);
      drive_sample(0, 50); drive_sample(1, 50); drive_sample(12, 50);
      exp_fe++;
      fill(300);
      send_frame(2, 1'b1);
      checkpoint("ferr");

      // Overrun: second frame dropped while the first is held.
      sample_ready = 1'b0;
      fill(1000);
      send_frame(0, 1'b1);
      idle(LAT + 1);
      check_val("ovr_held_valid", sample_valid, 1);
      fill(2000);
      send_frame(0, 1'b0);
      exp_ovr++;
      idle(LAT + 1);
      check_val("ovr_still_valid", sample_valid, 1);
      sample_ready = 1'b1;
      @(posedge clk);
      #1;
      sample_ready = 1'b0;
      @(negedge clk);
      check_val("ovr_valid_drop", sample_valid, 0);
      sample_ready = 1'b1;
      checkpoint("ovr");

`ifdef OPL2_MIXER_DC_BLOCK_EN
      reset_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(1);
      pan_left = '1; pan_right = '0;
      fill(1000);
      for (int f = 0; f < 5; f++) send_frame(0, 1'b1);
      idle(LAT + 3);
      for (int i = 1; i < act_q[0].size(); i++)
         check_val("dc_decay", (act_q[0][i].l < act_q[0][i-1].l && act_q[0][i].l > 0) ? 1 : 0, 1);
      checkpoint("dc");
`endif

      // Random frames, random pans and gaps, ready held high.
      for (int f = 0; f < 24; f++) begin
         pan_left  = NCH'($urandom_range(511, 0));
         pan_right = NCH'($urandom_range(511, 0));
         for (int i = 0; i < NCH; i++) fr[i] = int'($urandom_range(65535, 0)) - 32768;
         send_frame(2, 1'b1);
         if ($urandom_range(1, 0) == 1) idle(1);
      end
      checkpoint("rand");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
